// File: rtl/alu_1bit.sv
// Registered 1-bit ALU (NOT/OR/AND/ADD) with a single-cycle valid handshake.
// Optional zero flag output enabled by defining ALU_1BIT_ZERO_FLAG_EN.
module alu_1bit #(
    parameter logic OUT_RST_VAL = 1'b0,
    localparam int unsigned F_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a,
    input  logic           b,
    input  logic           cin,
    input  logic [F_W-1:0] f,
    input  logic           in_valid,
    output logic           out,
    output logic           cout,
`ifdef ALU_1BIT_ZERO_FLAG_EN
    output logic           out_valid,
    output logic           zero
`else
    output logic           out_valid
`endif
);

    typedef enum logic [F_W-1:0] {
        OP_NOT = 2'b00,
        OP_OR  = 2'b01,
        OP_AND = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    logic res_out;
    logic res_cout;

    // Combinational result of the currently presented operands
    always_comb begin
        res_out  = 1'b0;
        res_cout = 1'b0;
        unique case (op_e'(f))
            OP_NOT: res_out = ~a;
            OP_OR:  res_out = a | b;
            OP_AND: res_out = a & b;
            OP_ADD: begin
                res_out  = a ^ b ^ cin;
                res_cout = (a & b) | (a & cin) | (b & cin);
            end
            default: begin
                res_out  = 1'b0;
                res_cout = 1'b0;
            end
        endcase
    end

    // Capture on valid, hold otherwise; valid pulses once per accepted op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= OUT_RST_VAL;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= res_out;
                cout <= res_cout;
            end
        end
    end

`ifdef ALU_1BIT_ZERO_FLAG_EN
    // Zero flag tracks the registered result, so it shares its timing and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= ~OUT_RST_VAL;
        end else if (in_valid) begin
            zero <= ~(res_out | res_cout);
        end
    end
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// Scoreboard bench for alu_1bit: stimulus pushes hand-computed results,
// a monitor pops and compares on every out_valid pulse.
module tb_alu_1bit;

    localparam logic RST_VAL = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       cin = 1'b0;
    logic [1:0] f = 2'b00;
    logic       in_valid = 1'b0;
    logic       out;
    logic       cout;
    logic       out_valid;
`ifdef ALU_1BIT_ZERO_FLAG_EN
    logic       zero;
`endif

    // Hand-computed truth tables indexed by {f,a,b,cin}
    logic [31:0] exp_out_tbl  = 32'h96C0_FC0F;
    logic [31:0] exp_cout_tbl = 32'hE800_0000;

    logic [1:0] sb [$];
    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    int pulses   = 0;

    alu_1bit #(.OUT_RST_VAL(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .f         (f),
        .in_valid  (in_valid),
        .out       (out),
        .cout      (cout),
`ifdef ALU_1BIT_ZERO_FLAG_EN
        .out_valid (out_valid),
        .zero      (zero)
`else
        .out_valid (out_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] lookup(input logic [1:0] ff, input logic aa,
                                          input logic bb, input logic cc);
        logic [4:0] idx;
        idx = {ff, aa, bb, cc};
        return {exp_out_tbl[idx], exp_cout_tbl[idx]};
    endfunction

    task automatic issue(input logic [1:0] ff, input logic aa, input logic bb,
                         input logic cc, input logic v);
        @(negedge clk);
        f = ff; a = aa; b = bb; cin = cc; in_valid = v;
        if (v) begin
            sb.push_back(lookup(ff, aa, bb, cc));
            accepted++;
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 4'(out_valid), 4'(0));
                end else begin
                    e = sb.pop_front();
                    check("result_out_cout", 4'({out, cout}), 4'(e));
`ifdef ALU_1BIT_ZERO_FLAG_EN
                    check("result_zero", 4'(zero), 4'(~(e[1] | e[0])));
`endif
                end
            end
        end
    end

    initial begin
        // Reset state, independent of clock edges
        #2;
        check("reset_out", 4'(out), 4'(RST_VAL));
        check("reset_cout", 4'(cout), 4'(0));
        check("reset_out_valid", 4'(out_valid), 4'(0));
`ifdef ALU_1BIT_ZERO_FLAG_EN
        check("reset_zero", 4'(zero), 4'(~RST_VAL));
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive, back-to-back
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            issue(v[4:3], v[2], v[1], v[0], 1'b1);
        end

        // Don't-care isolation
        issue(2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ALU_1BIT_ZERO_FLAG_EN
        issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
`endif

        // Hold with in_valid low and changing inputs
        issue(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue(2'(i), 1'(i), 1'(i + 1), 1'b1, 1'b0);
            @(posedge clk);
            #2;
            check("hold_out_cout", 4'({out, cout}), 4'b0010);
            check("hold_out_valid", 4'(out_valid), 4'(0));
        end

        // Reset between edges after a capture; a pending op must be dropped
        issue(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        f = 2'b00; a = 1'b0; in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_out", 4'(out), 4'(RST_VAL));
        check("midrst_cout", 4'(cout), 4'(0));
        check("midrst_out_valid", 4'(out_valid), 4'(0));
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("postrst_out", 4'({out, cout}), 4'({RST_VAL, 1'b0}));

        // Random operands with random in_valid
        for (int i = 0; i < 50; i++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Drain with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        check("scoreboard_drained", 4'(sb.size()), 4'(0));
        checks++;
        if (pulses != accepted) begin
            errors++;
            $display("FAIL pulse_count: got %0d expected %0d", pulses, accepted);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
